// File: rtl/pll_drp_pkg.sv
// pll_drp_pkg: shared types, DRP register map, field positions and helpers
// for the PLL divider reprogramming controller.
//   state_e      - controller FSM states
//   div_enc_t    - encoded divider fields {edge, nocount, high, low}
//   div_encode() - divide value -> encoded fields
//   drp_addr()   - (channel, register index) -> DRP address
//   is_legal()   - range check of a (channel, divide) request
package pll_drp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT_RD,
        ST_WR,
        ST_WAIT_WR,
        ST_REL,
        ST_WAIT_LOCK
    } state_e;

    typedef struct packed {
        logic       edge_bit;
        logic       nocount;
        logic [5:0] high;
        logic [5:0] low;
    } div_enc_t;

    localparam logic [2:0] CHAN_CLKFBOUT = 3'd6;
    localparam logic [2:0] CHAN_DIVCLK   = 3'd7;

    localparam logic [6:0] DIV_MAX        = 7'd64;
    localparam logic [6:0] DIV_MAX_DIVCLK = 7'd56;

    // DRP register map
    localparam logic [6:0] ADDR_CLKOUT0_REG1  = 7'h08;
    localparam logic [6:0] ADDR_CLKOUT0_REG2  = 7'h09;
    localparam logic [6:0] ADDR_CLKOUT1_REG1  = 7'h0A;
    localparam logic [6:0] ADDR_CLKOUT1_REG2  = 7'h0B;
    localparam logic [6:0] ADDR_CLKOUT2_REG1  = 7'h0C;
    localparam logic [6:0] ADDR_CLKOUT2_REG2  = 7'h0D;
    localparam logic [6:0] ADDR_CLKOUT3_REG1  = 7'h0E;
    localparam logic [6:0] ADDR_CLKOUT3_REG2  = 7'h0F;
    localparam logic [6:0] ADDR_CLKOUT4_REG1  = 7'h10;
    localparam logic [6:0] ADDR_CLKOUT4_REG2  = 7'h11;
    localparam logic [6:0] ADDR_CLKOUT5_REG1  = 7'h06;
    localparam logic [6:0] ADDR_CLKOUT5_REG2  = 7'h07;
    localparam logic [6:0] ADDR_CLKFBOUT_REG1 = 7'h14;
    localparam logic [6:0] ADDR_CLKFBOUT_REG2 = 7'h15;
    localparam logic [6:0] ADDR_DIVCLK        = 7'h16;

    // Field bit positions
    localparam int FLD_W             = 6;
    localparam int REG1_HIGH_LSB     = 6;
    localparam int REG1_LOW_LSB      = 0;
    localparam int REG2_EDGE_BIT     = 7;
    localparam int REG2_NOCOUNT_BIT  = 6;
    localparam int DIVCLK_EDGE_BIT   = 13;
    localparam int DIVCLK_NOCOUNT_BIT = 12;

    // Low is computed modulo 64, so a field that would hold 64 becomes 0.
    function automatic div_enc_t div_encode(input logic [6:0] divide);
        div_enc_t enc;
        enc.high     = divide[6:1];
        enc.low      = divide[5:0] - divide[6:1];
        enc.edge_bit = divide[0];
        enc.nocount  = (divide == 7'd1);
        return enc;
    endfunction

    function automatic logic [6:0] drp_addr(input logic [2:0] chan, input logic reg_idx);
        logic [6:0] a1;
        logic [6:0] a2;
        case (chan)
            3'd0:    begin a1 = ADDR_CLKOUT0_REG1;  a2 = ADDR_CLKOUT0_REG2;  end
            3'd1:    begin a1 = ADDR_CLKOUT1_REG1;  a2 = ADDR_CLKOUT1_REG2;  end
            3'd2:    begin a1 = ADDR_CLKOUT2_REG1;  a2 = ADDR_CLKOUT2_REG2;  end
            3'd3:    begin a1 = ADDR_CLKOUT3_REG1;  a2 = ADDR_CLKOUT3_REG2;  end
            3'd4:    begin a1 = ADDR_CLKOUT4_REG1;  a2 = ADDR_CLKOUT4_REG2;  end
            3'd5:    begin a1 = ADDR_CLKOUT5_REG1;  a2 = ADDR_CLKOUT5_REG2;  end
            3'd6:    begin a1 = ADDR_CLKFBOUT_REG1; a2 = ADDR_CLKFBOUT_REG2; end
            default: begin a1 = ADDR_DIVCLK;        a2 = ADDR_DIVCLK;        end
        endcase
        return reg_idx ? a2 : a1;
    endfunction

    function automatic logic is_legal(input logic [2:0] chan, input logic [6:0] divide);
        logic [6:0] max_div;
        max_div = (chan == CHAN_DIVCLK) ? DIV_MAX_DIVCLK : DIV_MAX;
        return (divide != 7'd0) && (divide <= max_div);
    endfunction

endpackage

// File: rtl/pll_drp_merge.sv
// pll_drp_merge: combinational read-modify-write merge of the encoded
// divider fields into the word read back from the DRP.
//   chan_i    - target channel (7 = DIVCLK, single register)
//   reg_idx_i - 0 = first register (high/low), 1 = second (edge/nocount)
//   do_i      - word read from the DRP
//   enc_i     - encoded divider fields
//   di_o      - word to write back
module pll_drp_merge
    import pll_drp_pkg::*;
(
    input  logic [2:0]  chan_i,
    input  logic        reg_idx_i,
    input  logic [15:0] do_i,
    input  div_enc_t    enc_i,
    output logic [15:0] di_o
);

    // NOTE: di_o gets a full default first so no path through the
    // branches below can leave it unassigned and infer a latch.
    always_comb begin
        di_o = do_i;
        if (chan_i == CHAN_DIVCLK) begin
            di_o[DIVCLK_EDGE_BIT]              = enc_i.edge_bit;
            di_o[DIVCLK_NOCOUNT_BIT]           = enc_i.nocount;
            di_o[REG1_HIGH_LSB +: FLD_W]       = enc_i.high;
            di_o[REG1_LOW_LSB +: FLD_W]        = enc_i.low;
        end else if (!reg_idx_i) begin
            di_o[REG1_HIGH_LSB +: FLD_W]       = enc_i.high;
            di_o[REG1_LOW_LSB +: FLD_W]        = enc_i.low;
        end else begin
            di_o[REG2_EDGE_BIT]                = enc_i.edge_bit;
            di_o[REG2_NOCOUNT_BIT]             = enc_i.nocount;
        end
    end

endmodule

// File: rtl/pll_drp_ctrl.sv
// pll_drp_ctrl: DRP master that reprograms one PLL output divider.
// Holds the PLL in reset, read-modify-writes the divider register(s),
// releases reset and waits for LOCKED.
//   DCLK, RST        - clock, asynchronous active-high reset
//   SEN/SCHAN/SDIVIDE- request (sampled only when idle)
//   SRDY/SERR/BUSY   - completion pulse, error pulse, busy level
//   PLL_RST, LOCKED  - PLL reset output, PLL lock input
//   DADDR/DEN/DWE/DI/DO/DRDY - DRP master port
module pll_drp_ctrl
    import pll_drp_pkg::*;
#(
    parameter int unsigned DRDY_TIMEOUT = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096
) (
    input  logic        DCLK,
    input  logic        RST,
    input  logic        SEN,
    input  logic [2:0]  SCHAN,
    input  logic [6:0]  SDIVIDE,
    output logic        SRDY,
    output logic        SERR,
    output logic        BUSY,
    output logic        PLL_RST,
    input  logic        LOCKED,
    output logic [6:0]  DADDR,
    output logic        DEN,
    output logic        DWE,
    output logic [15:0] DI,
    input  logic [15:0] DO,
    input  logic        DRDY
);

    localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
    // Abort on the cycle whose increment would make the count reach the limit.
    localparam logic [CNT_W-1:0] DRDY_LAST = CNT_W'(DRDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [2:0]       chan_q, chan_d;
    logic [6:0]       div_q, div_d;
    logic             reg_idx_q, reg_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             pll_rst_q, pll_rst_d;
    logic             srdy_q, srdy_d;
    logic             serr_q, serr_d;
    logic             dwe_q, dwe_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             abort;

    div_enc_t         enc;
    logic [15:0]      merged;

    assign enc = div_encode(div_q);

    pll_drp_merge u_merge (
        .chan_i    (chan_q),
        .reg_idx_i (reg_idx_q),
        .do_i      (DO),
        .enc_i     (enc),
        .di_o      (merged)
    );

    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        div_d     = div_q;
        reg_idx_d = reg_idx_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        pll_rst_d = pll_rst_q;
        srdy_d    = 1'b0;
        serr_d    = 1'b0;
        dwe_d     = dwe_q;
        daddr_d   = daddr_q;
        di_d      = di_q;
        abort     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (SEN) begin
                    if (is_legal(SCHAN, SDIVIDE)) begin
                        chan_d    = SCHAN;
                        div_d     = SDIVIDE;
                        reg_idx_d = 1'b0;
                        daddr_d   = drp_addr(SCHAN, 1'b0);
                        dwe_d     = 1'b0;
                        busy_d    = 1'b1;
                        pll_rst_d = 1'b1;
                        state_d   = ST_RD;
                    end else begin
                        serr_d = 1'b1;
                    end
                end
            end
            ST_RD: begin
                cnt_d   = '0;
                state_d = ST_WAIT_RD;
            end
            ST_WAIT_RD: begin
                if (DRDY) begin
                    di_d    = merged;
                    dwe_d   = 1'b1;
                    state_d = ST_WR;
                end else if (cnt_q == DRDY_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR: begin
                cnt_d   = '0;
                state_d = ST_WAIT_WR;
            end
            ST_WAIT_WR: begin
                if (DRDY) begin
                    if (chan_q != CHAN_DIVCLK && !reg_idx_q) begin
                        reg_idx_d = 1'b1;
                        daddr_d   = drp_addr(chan_q, 1'b1);
                        dwe_d     = 1'b0;
                        state_d   = ST_RD;
                    end else begin
                        state_d = ST_REL;
                    end
                end else if (cnt_q == DRDY_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REL: begin
                pll_rst_d = 1'b0;
                cnt_d     = '0;
                state_d   = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (LOCKED) begin
                    srdy_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LOCK_LAST) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            serr_d    = 1'b1;
            pll_rst_d = 1'b0;
            busy_d    = 1'b0;
            state_d   = ST_IDLE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge DCLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            chan_q    <= '0;
            div_q     <= '0;
            reg_idx_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            pll_rst_q <= 1'b0;
            srdy_q    <= 1'b0;
            serr_q    <= 1'b0;
            dwe_q     <= 1'b0;
            daddr_q   <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            chan_q    <= chan_d;
            div_q     <= div_d;
            reg_idx_q <= reg_idx_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pll_rst_q <= pll_rst_d;
            srdy_q    <= srdy_d;
            serr_q    <= serr_d;
            dwe_q     <= dwe_d;
            daddr_q   <= daddr_d;
            di_q      <= di_d;
        end
    end

    // DEN is decoded from the one-cycle access states so it can never stretch.
    assign DEN     = (state_q == ST_RD) || (state_q == ST_WR);
    assign DWE     = dwe_q;
    assign DADDR   = daddr_q;
    assign DI      = di_q;
    assign SRDY    = srdy_q;
    assign SERR    = serr_q;
    assign BUSY    = busy_q;
    assign PLL_RST = pll_rst_q;

endmodule

// File: tb/tb_pll_drp_ctrl.sv
// tb_pll_drp_ctrl: scoreboard bench for pll_drp_ctrl. Stimulus pushes the
// expected DRP writes and status pulses; a monitor pops and compares them
// whenever the DUT presents a write or a status pulse.
module tb_pll_drp_ctrl;

    localparam int DRDY_TO = 16;

    logic        DCLK, RST, SEN, SRDY, SERR, BUSY, PLL_RST, LOCKED;
    logic [2:0]  SCHAN;
    logic [6:0]  SDIVIDE, DADDR;
    logic        DEN, DWE, DRDY;
    logic [15:0] DI, DO;

    typedef struct {
        logic [6:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    bit          exp_st[$];   // 1 = SERR, 0 = SRDY
    logic [15:0] rd_q[$];     // read data the DRP model returns, in order

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int den_count = 0;
    int status_seen = 0;
    int status_cyc = 0;
    bit drdy_en = 1'b1;

    pll_drp_ctrl dut (
        .DCLK    (DCLK),
        .RST     (RST),
        .SEN     (SEN),
        .SCHAN   (SCHAN),
        .SDIVIDE (SDIVIDE),
        .SRDY    (SRDY),
        .SERR    (SERR),
        .BUSY    (BUSY),
        .PLL_RST (PLL_RST),
        .LOCKED  (LOCKED),
        .DADDR   (DADDR),
        .DEN     (DEN),
        .DWE     (DWE),
        .DI      (DI),
        .DO      (DO),
        .DRDY    (DRDY)
    );

    initial begin
        DCLK = 1'b0;
        forever #5 DCLK = ~DCLK;
    end

    initial forever begin
        @(posedge DCLK);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Zero-wait DRP slave: DRDY in the cycle after DEN, read data from rd_q.
    initial begin
        bit pend, pend_rd;
        DRDY = 1'b0;
        DO   = 16'h0;
        forever begin
            @(negedge DCLK);
            pend    = DEN && drdy_en;
            pend_rd = DEN && !DWE && drdy_en;
            @(posedge DCLK);
            #1;
            DRDY = pend;
            if (pend_rd && rd_q.size() > 0) DO = rd_q.pop_front();
            else DO = 16'h0;
        end
    end

    // Monitor / scoreboard
    initial forever begin
        @(negedge DCLK);
        if (DEN) den_count++;
        if (DEN && DWE) begin
            if (exp_wr.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", DADDR, DI);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", DADDR, w.addr);
                check("wr_data", DI, w.data);
            end
        end
        if (SRDY || SERR) begin
            status_seen++;
            status_cyc = cyc;
            check("status_exclusive", SRDY & SERR, 0);
            if (exp_st.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_status: got SRDY=%0b SERR=%0b, none expected", SRDY, SERR);
            end else begin
                bit e;
                e = exp_st.pop_front();
                check("status_kind_serr", SERR, e);
            end
        end
    end

    task automatic req(input logic [2:0] ch, input logic [6:0] dv);
        @(negedge DCLK);
        SEN = 1'b1;
        SCHAN = ch;
        SDIVIDE = dv;
        @(negedge DCLK);
        SEN = 1'b0;
    endtask

    task automatic wait_status(input int s0, input int max_cyc);
        int k;
        k = 0;
        #1;
        while (status_seen == s0 && k < max_cyc) begin
            @(negedge DCLK);
            #1;
            k++;
        end
        check("status_arrived", status_seen != s0, 1);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    initial begin
        int s0, d0, n0, k;
        bit held;

        RST = 1'b1;
        SEN = 1'b0;
        SCHAN = 3'd0;
        SDIVIDE = 7'd0;
        LOCKED = 1'b0;
        #2;
        check("reset_outputs", {SRDY, SERR, BUSY, PLL_RST, DEN, DWE, DADDR, DI}, 0);
        repeat (3) @(posedge DCLK);
        @(negedge DCLK);
        RST = 1'b0;

        // CLKOUT0, divide 5: high 2, low 3, edge 1, nocount 0
        rd_q.push_back(16'hF000);
        rd_q.push_back(16'h0000);
        push_wr(7'h08, 16'hF083);
        push_wr(7'h09, 16'h0080);
        d0 = den_count;
        req(3'd0, 7'd5);
        n0 = cyc;
        check("t1_busy_after_sen", BUSY, 1);
        check("t1_pllrst_after_sen", PLL_RST, 1);
        check("t1_first_den", DEN, 1);
        check("t1_first_addr", DADDR, 7'h08);
        held = PLL_RST;
        repeat (8) begin
            @(negedge DCLK);
            held = held & PLL_RST;
        end
        check("t1_pllrst_held", held, 1);
        @(negedge DCLK);
        check("t1_release_cycle", cyc - n0, 9);
        check("t1_pllrst_released", PLL_RST, 0);
        check("t1_busy_in_lock_wait", BUSY, 1);
        check("t1_den_count", den_count - d0, 4);
        repeat (10) @(negedge DCLK);
        exp_st.push_back(1'b0);
        s0 = status_seen;
        LOCKED = 1'b1;
        wait_status(s0, 5);
        check("t1_busy_cleared", BUSY, 0);
        @(negedge DCLK);
        LOCKED = 1'b0;

        // DIVCLK, divide 1: high 0, low 1, edge 1, nocount 1
        rd_q.push_back(16'hC000);
        push_wr(7'h16, 16'hF001);
        exp_st.push_back(1'b0);
        d0 = den_count;
        s0 = status_seen;
        req(3'd7, 7'd1);
        repeat (8) @(negedge DCLK);
        LOCKED = 1'b1;
        wait_status(s0, 10);
        check("t2_den_count", den_count - d0, 2);
        @(negedge DCLK);
        LOCKED = 1'b0;

        // CLKOUT5, divide 64 (largest legal): high 32, low 32
        rd_q.push_back(16'h0ABC);
        rd_q.push_back(16'hFFFF);
        push_wr(7'h06, 16'h0820);
        push_wr(7'h07, 16'hFF3F);
        exp_st.push_back(1'b0);
        s0 = status_seen;
        req(3'd5, 7'd64);
        repeat (10) @(negedge DCLK);
        LOCKED = 1'b1;
        wait_status(s0, 10);
        @(negedge DCLK);
        LOCKED = 1'b0;

        // DIVCLK, divide 56 (largest legal for DIVCLK): high 28, low 28
        rd_q.push_back(16'h0000);
        push_wr(7'h16, 16'h071C);
        exp_st.push_back(1'b0);
        s0 = status_seen;
        req(3'd7, 7'd56);
        repeat (6) @(negedge DCLK);
        LOCKED = 1'b1;
        wait_status(s0, 10);
        @(negedge DCLK);
        LOCKED = 1'b0;

        // Illegal requests: SERR pulse, no DRP traffic, PLL_RST stays low
        for (int i = 0; i < 3; i++) begin
            logic [2:0] ch;
            logic [6:0] dv;
            ch = (i == 2) ? 3'd7 : 3'd0;
            dv = (i == 0) ? 7'd0 : ((i == 1) ? 7'd65 : 7'd57);
            exp_st.push_back(1'b1);
            d0 = den_count;
            s0 = status_seen;
            req(ch, dv);
            check("illegal_pllrst", PLL_RST, 0);
            check("illegal_busy", BUSY, 0);
            wait_status(s0, 3);
            repeat (3) @(negedge DCLK);
            check("illegal_no_den", den_count - d0, 0);
            check("illegal_pllrst_after", PLL_RST, 0);
        end

        // DRDY withheld: SERR rises DRDY_TO edges after DEN drops
        drdy_en = 1'b0;
        exp_st.push_back(1'b1);
        d0 = den_count;
        s0 = status_seen;
        req(3'd3, 7'd7);
        n0 = cyc;
        check("to_den", DEN, 1);
        wait_status(s0, 40);
        check("to_serr_cycle", status_cyc - n0, DRDY_TO + 1);
        check("to_pllrst", PLL_RST, 0);
        check("to_busy", BUSY, 0);
        check("to_den_count", den_count - d0, 1);
        drdy_en = 1'b1;
        repeat (2) @(negedge DCLK);

        // SEN while busy is ignored. CLKOUT1, divide 10: high 5, low 5
        rd_q.push_back(16'h1234);
        rd_q.push_back(16'h5678);
        push_wr(7'h0A, 16'h1145);
        push_wr(7'h0B, 16'h5638);
        exp_st.push_back(1'b0);
        d0 = den_count;
        s0 = status_seen;
        req(3'd1, 7'd10);
        repeat (2) @(negedge DCLK);
        SEN = 1'b1;
        SCHAN = 3'd7;
        SDIVIDE = 7'd3;
        @(negedge DCLK);
        SEN = 1'b0;
        repeat (8) @(negedge DCLK);
        LOCKED = 1'b1;
        wait_status(s0, 10);
        @(negedge DCLK);
        LOCKED = 1'b0;
        repeat (10) @(negedge DCLK);
        check("busy_sen_den_count", den_count - d0, 4);
        check("busy_sen_idle", BUSY, 0);

        // RST during WAIT_WR. CLKOUT2, divide 3: high 1, low 2, edge 1
        rd_q.push_back(16'hA000);
        push_wr(7'h0C, 16'hA042);
        d0 = den_count;
        req(3'd2, 7'd3);
        k = 0;
        #1;
        while (den_count < d0 + 2 && k < 20) begin
            @(negedge DCLK);
            #1;
            k++;
        end
        check("rst_reached_write", den_count - d0, 2);
        @(posedge DCLK);
        #2;
        check("rst_pre_pllrst", PLL_RST, 1);
        RST = 1'b1;
        #1;
        check("rst_async_outputs", {SRDY, SERR, BUSY, PLL_RST, DEN, DWE, DADDR, DI}, 0);
        repeat (2) @(posedge DCLK);
        @(negedge DCLK);
        RST = 1'b0;
        rd_q.delete();
        repeat (2) @(negedge DCLK);

        // Normal completion after reset. CLKOUT4, divide 2: high 1, low 1
        rd_q.push_back(16'h0FFF);
        rd_q.push_back(16'h00C0);
        push_wr(7'h10, 16'h0041);
        push_wr(7'h11, 16'h0000);
        exp_st.push_back(1'b0);
        s0 = status_seen;
        req(3'd4, 7'd2);
        repeat (10) @(negedge DCLK);
        LOCKED = 1'b1;
        wait_status(s0, 10);
        @(negedge DCLK);
        LOCKED = 1'b0;
        repeat (3) @(negedge DCLK);

        check("queues_drained", exp_wr.size() + exp_st.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
